// File: rtl/rpu_slot_scheduler.sv
// rtl/rpu_slot_scheduler.sv - round-robin packet slot scheduler across RPU cores
// Hands out {core, tag} per packet request and takes slots back on release.
module rpu_slot_scheduler #(
  parameter int CORE_COUNT = 16,
  parameter int CORE_WIDTH = $clog2(CORE_COUNT),
  parameter int SLOT_COUNT = 16,
  parameter int SLOT_WIDTH = $clog2(SLOT_COUNT + 1),
  parameter int TAG_WIDTH  = (SLOT_WIDTH > 5) ? SLOT_WIDTH : 5,
  parameter int PORT_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PORT_WIDTH-1:0] req_port,
  output logic                  grant_valid,
  input  logic                  grant_ready,
  output logic [CORE_WIDTH-1:0] grant_core,
  output logic [TAG_WIDTH-1:0]  grant_tag,
  output logic [PORT_WIDTH-1:0] grant_port,
  input  logic                  rel_valid,
  input  logic [CORE_WIDTH-1:0] rel_core,
  input  logic [TAG_WIDTH-1:0]  rel_tag,
  output logic                  rel_err,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CORE_WIDTH-1:0] cfg_core,
  input  logic [SLOT_WIDTH-1:0] cfg_slots,
  input  logic [CORE_COUNT-1:0] core_en,
  input  logic [CORE_WIDTH-1:0] stat_core,
  output logic [SLOT_WIDTH-1:0] stat_free
);

  localparam int IDX_WIDTH = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, PICK, GRANT} state_t;

  state_t                state_q, state_d;
  logic [SLOT_COUNT-1:0] bitmap_q [CORE_COUNT];
  logic [SLOT_COUNT-1:0] bitmap_d [CORE_COUNT];
  logic [SLOT_COUNT-1:0] eff_map  [CORE_COUNT];
  logic [CORE_WIDTH-1:0] rr_q;
  logic                  run_q;

  logic                  rel_hit, rel_bad;
  logic [IDX_WIDTH-1:0]  rel_bit;
  logic [SLOT_COUNT-1:0] rel_mask;
  logic [SLOT_COUNT-1:0] cfg_mask;
  logic                  cfg_fire, req_fire, pick_fire;
  logic                  pick_found;
  logic [CORE_WIDTH-1:0] pick_core, cand;
  logic [SLOT_COUNT-1:0] pick_map;
  logic [IDX_WIDTH-1:0]  pick_bit;
  logic [SLOT_WIDTH-1:0] stat_cnt;

  // A release is good only if it names a real slot that is currently allocated.
  always_comb begin
    rel_hit = 1'b0;
    rel_bit = IDX_WIDTH'(rel_tag - TAG_WIDTH'(1));
    if (rel_valid && (rel_tag != '0) && (int'(rel_tag) <= SLOT_COUNT) &&
        (int'(rel_core) < CORE_COUNT))
      rel_hit = ~bitmap_q[rel_core][rel_bit];
    rel_bad  = rel_valid & ~rel_hit;
    rel_mask = rel_hit ? (SLOT_COUNT'(1) << rel_bit) : '0;
  end

  // Releases landing this cycle are already visible to the search.
  always_comb begin
    for (int c = 0; c < CORE_COUNT; c++)
      eff_map[c] = bitmap_q[c] | ((rel_hit && (int'(rel_core) == c)) ? rel_mask : '0);
  end

  always_comb begin
    for (int j = 0; j < SLOT_COUNT; j++)
      cfg_mask[j] = (j < int'(cfg_slots));
  end

  // Descending offset scan so the core closest after rr_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_core  = rr_q;
    cand       = '0;
    for (int i = CORE_COUNT; i >= 1; i--) begin
      cand = CORE_WIDTH'((int'(rr_q) + i) % CORE_COUNT);
      if (core_en[cand] && (eff_map[cand] != '0)) begin
        pick_found = 1'b1;
        pick_core  = cand;
      end
    end
    pick_map = eff_map[pick_core];
    pick_bit = '0;
    for (int j = SLOT_COUNT - 1; j >= 0; j--)
      if (pick_map[j]) pick_bit = IDX_WIDTH'(j);
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    cfg_ready = 1'b0;
    cfg_fire  = 1'b0;
    req_fire  = 1'b0;
    pick_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        req_ready = run_q & ~cfg_valid;
        cfg_fire  = cfg_valid;
        req_fire  = req_valid & req_ready;
        if (req_fire) state_d = PICK;
      end
      PICK: begin
        if (pick_found) begin
          pick_fire = 1'b1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      bitmap_d[c] = eff_map[c];
      if (cfg_fire && (int'(cfg_core) == c))
        bitmap_d[c] = cfg_mask;
      if (pick_fire && (int'(pick_core) == c))
        bitmap_d[c] = eff_map[c] & ~(SLOT_COUNT'(1) << pick_bit);
    end
  end

  always_comb begin
    stat_cnt = '0;
    if (int'(stat_core) < CORE_COUNT)
      for (int j = 0; j < SLOT_COUNT; j++)
        stat_cnt = stat_cnt + SLOT_WIDTH'(bitmap_q[stat_core][j]);
  end

  assign grant_valid = (state_q == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CORE_COUNT; c++) bitmap_q[c] <= '0;
      rr_q       <= CORE_WIDTH'(CORE_COUNT - 1);
      run_q      <= 1'b0;
      grant_core <= '0;
      grant_tag  <= '0;
      grant_port <= '0;
      rel_err    <= 1'b0;
      stat_free  <= '0;
    end else begin
      for (int c = 0; c < CORE_COUNT; c++) bitmap_q[c] <= bitmap_d[c];
      run_q     <= 1'b1;
      rel_err   <= rel_bad;
      stat_free <= stat_cnt;
      if (req_fire) grant_port <= req_port;
      if (pick_fire) begin
        rr_q       <= pick_core;
        grant_core <= pick_core;
        grant_tag  <= TAG_WIDTH'(pick_bit) + TAG_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_rpu_slot_scheduler.sv
// tb/tb_rpu_slot_scheduler.sv - directed and randomized checks of rpu_slot_scheduler
module tb_rpu_slot_scheduler;
  localparam int CC = 16;
  localparam int CW = 4;
  localparam int SC = 16;
  localparam int SW = 5;
  localparam int TW = 5;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [PW-1:0] req_port = '0;
  logic          grant_valid, grant_ready = 1'b0;
  logic [CW-1:0] grant_core;
  logic [TW-1:0] grant_tag;
  logic [PW-1:0] grant_port;
  logic          rel_valid = 1'b0;
  logic [CW-1:0] rel_core = '0;
  logic [TW-1:0] rel_tag = '0;
  logic          rel_err;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [CW-1:0] cfg_core = '0;
  logic [SW-1:0] cfg_slots = '0;
  logic [CC-1:0] core_en = '0;
  logic [CW-1:0] stat_core = '0;
  logic [SW-1:0] stat_free;

  int checks = 0;
  int errors = 0;

  // Reference: per-core set of free tags, last served core, enable mask.
  bit            mfree [CC][SC+2];
  int            mrr;
  logic [CC-1:0] men;

  always #5 clk = ~clk;

  rpu_slot_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
    .grant_valid(grant_valid), .grant_ready(grant_ready),
    .grant_core(grant_core), .grant_tag(grant_tag), .grant_port(grant_port),
    .rel_valid(rel_valid), .rel_core(rel_core), .rel_tag(rel_tag), .rel_err(rel_err),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_core(cfg_core), .cfg_slots(cfg_slots),
    .core_en(core_en), .stat_core(stat_core), .stat_free(stat_free)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mcount(input int c);
    int n = 0;
    for (int t = 1; t <= SC; t++) if (mfree[c][t]) n++;
    return n;
  endfunction

  function automatic void mpredict(output int pc, output int pt);
    pc = -1;
    pt = 0;
    for (int i = CC; i >= 1; i--)
      if (men[(mrr + i) % CC] && mcount((mrr + i) % CC) > 0) pc = (mrr + i) % CC;
    if (pc >= 0)
      for (int t = SC; t >= 1; t--) if (mfree[pc][t]) pt = t;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; grant_ready = 1'b0; rel_valid = 1'b0; cfg_valid = 1'b0;
    repeat (2) tick();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_core", grant_core, 0);
    chk("rst_grant_tag", grant_tag, 0);
    chk("rst_rel_err", rel_err, 0);
    chk("rst_stat_free", stat_free, 0);
    chk("rst_req_ready", req_ready, 0);
    for (int c = 0; c < CC; c++)
      for (int t = 0; t < SC + 2; t++) mfree[c][t] = 1'b0;
    mrr = CC - 1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_cfg_ready", cfg_ready, 1);
  endtask

  task automatic do_cfg(input int c, input int n);
    int k;
    cfg_valid = 1'b1; cfg_core = CW'(c); cfg_slots = SW'(n);
    #1;
    k = 0;
    while (!cfg_ready && k < 50) begin tick(); k++; end
    chk("cfg_ready", cfg_ready, 1);
    chk("cfg_blocks_req", req_ready, 0);
    tick();
    cfg_valid = 1'b0;
    for (int t = 1; t <= SC; t++) mfree[c][t] = (t <= n);
  endtask

  task automatic set_en(input logic [CC-1:0] m);
    core_en = m;
    men = m;
  endtask

  task automatic do_req(input int port, input int hold, output int gc, output int gt);
    int pc, pt, k;
    mpredict(pc, pt);
    req_valid = 1'b1; req_port = PW'(port);
    #1;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    chk("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("lat_pick", grant_valid, 0);
    k = 0;
    while (!grant_valid && k < 4) begin tick(); k++; end
    chk("grant_valid", grant_valid, 1);
    chk("grant_core", grant_core, pc);
    chk("grant_tag", grant_tag, pt);
    chk("grant_port", grant_port, port);
    gc = int'(grant_core);
    gt = int'(grant_tag);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      tick();
      chk("hold_valid", grant_valid, 1);
      chk("hold_core", grant_core, pc);
      chk("hold_tag", grant_tag, pt);
      chk("hold_port", grant_port, port);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("grant_done", grant_valid, 0);
    if (pc >= 0) begin
      mfree[pc][pt] = 1'b0;
      mrr = pc;
    end
  endtask

  task automatic do_rel(input int c, input int t);
    int exp_err;
    exp_err = (t < 1 || t > SC) ? 1 : (mfree[c][t] ? 1 : 0);
    stat_core = CW'(c);
    rel_valid = 1'b1; rel_core = CW'(c); rel_tag = TW'(t);
    tick();
    rel_valid = 1'b0;
    chk("rel_err", rel_err, exp_err);
    if (exp_err == 0) mfree[c][t] = 1'b1;
    tick();
    chk("rel_err_pulse", rel_err, 0);
    chk("rel_stat_free", stat_free, mcount(c));
  endtask

  initial begin
    int gc, gt, k, pc, pt, op;
    int exp_core [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_tag  [8] = '{1, 1, 1, 1, 2, 2, 2, 2};

    do_reset();

    // Two slots on core 0, third request stalls until a slot comes back.
    do_cfg(0, 2);
    set_en(16'h0001);
    do_req(1, 0, gc, gt);
    chk("t1_core", gc, 0);
    chk("t1_tag", gt, 1);
    do_req(2, 0, gc, gt);
    chk("t2_core", gc, 0);
    chk("t2_tag", gt, 2);
    req_valid = 1'b1; req_port = 3'd5;
    #1;
    chk("stall_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_no_grant", grant_valid, 0);
      chk("stall_req_ready", req_ready, 0);
    end
    rel_valid = 1'b1; rel_core = '0; rel_tag = 5'd2;
    tick();
    rel_valid = 1'b0;
    k = 1;
    while (!grant_valid && k < 2) begin tick(); k++; end
    chk("unstall_valid", grant_valid, 1);
    chk("unstall_core", grant_core, 0);
    chk("unstall_tag", grant_tag, 2);
    chk("unstall_port", grant_port, 5);
    chk("unstall_rel_err", rel_err, 0);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;

    // Four cores, four slots each: round robin across cores first.
    do_reset();
    for (int c = 0; c < 4; c++) do_cfg(c, 4);
    set_en(16'h000F);
    for (int i = 0; i < 8; i++) begin
      do_req(i % 8, 0, gc, gt);
      chk("rr_core", gc, exp_core[i]);
      chk("rr_tag", gt, exp_tag[i]);
    end

    stat_core = '0;
    tick();
    tick();
    chk("stat_core0", stat_free, 2);
    do_rel(0, 3);
    do_rel(0, 0);
    do_rel(0, 17);
    chk("stat_after_bad", stat_free, 2);
    do_rel(0, 1);
    chk("stat_after_good", stat_free, 3);

    // Backpressure on the grant channel.
    do_req(6, 5, gc, gt);

    // Reset while a grant is pending clears it asynchronously.
    req_valid = 1'b1; req_port = 3'd4;
    tick();
    req_valid = 1'b0;
    k = 0;
    while (!grant_valid && k < 4) begin tick(); k++; end
    chk("pre_rst_grant", grant_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant_valid, 0);
    do_reset();
    stat_core = '0;
    tick();
    chk("rst_stat_core0", stat_free, 0);

    // Randomized operation mix against the reference.
    set_en(CC'($urandom) | 16'h0001);
    for (int c = 0; c < CC; c++) do_cfg(c, $urandom_range(0, 20));
    for (int r = 0; r < 80; r++) begin
      op = $urandom_range(0, 5);
      if (op == 0) begin
        do_cfg($urandom_range(0, CC - 1), $urandom_range(0, 20));
      end else if (op == 1) begin
        do_rel($urandom_range(0, CC - 1), $urandom_range(0, 18));
      end else if (op == 2) begin
        set_en(CC'($urandom));
      end else begin
        mpredict(pc, pt);
        if (pc >= 0) do_req($urandom_range(0, 7), $urandom_range(0, 2), gc, gt);
        else do_rel($urandom_range(0, CC - 1), $urandom_range(1, SC));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
